typing_game_ctrl: RTL and testbench

Game sequencer for the typing game. Sits between the push-button/keyboard front end and the minute countdown timer: runs a start-up countdown, gates the 10 ms tick into the timer while a round is live, accepts keystroke results, and keeps the BCD score and the binary miss count for the seven-segment display path. Ends the round on the timer's finish strobe.

---
 rtl/typing_game_ctrl.sv | 166 ++++++++++++++++
 tb/tb_typing_game_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/typing_game_ctrl.sv
// Typing-game sequencer: start-up countdown, round gating of the timer tick, BCD score / miss count.
// Optional PAUSE state is compiled in with `define TYPING_GAME_PAUSE_EN.
module typing_game_ctrl #(
    parameter int unsigned READY_SECS    = 3,
    parameter int unsigned TICKS_PER_SEC = 100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            start,
    input  logic            pause,
    input  logic            key_valid,
    input  logic            key_correct,
    output logic            key_ready,
    input  logic            time_up,
    output logic            timer_clear,
    output logic            timer_en,
    output logic [3:0]      ready_digit,
    output logic [0:3][3:0] score,
    output logic [7:0]      miss,
    output logic [2:0]      state,
    output logic            game_over
);

    localparam int unsigned SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned MISS_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [0:3][3:0]     score_q, score_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [3:0]          digit_q, digit_d;
    logic [SUB_W-1:0]    sub_q, sub_d;
    logic                timer_clear_q, timer_clear_d;
    logic                game_over_q, game_over_d;
    logic                key_accept;

`ifndef TYPING_GAME_PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause;
`endif

    // Saturating four-digit BCD increment; digit 0 is the most significant.
    function automatic logic [0:3][3:0] bcd_inc(input logic [0:3][3:0] v);
        logic [0:3][3:0] r;
        logic            carry;
        r     = v;
        carry = 1'b1;
        if (v != {4'd9, 4'd9, 4'd9, 4'd9}) begin
            for (int i = 3; i >= 0; i--) begin
                if (carry) begin
                    if (v[i] == 4'd9) begin
                        r[i] = 4'd0;
                    end else begin
                        r[i]  = v[i] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            score_q       <= '0;
            miss_q        <= '0;
            digit_q       <= '0;
            sub_q         <= '0;
            timer_clear_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            miss_q        <= miss_d;
            digit_q       <= digit_d;
            sub_q         <= sub_d;
            timer_clear_q <= timer_clear_d;
            game_over_q   <= game_over_d;
        end
    end

    assign key_ready  = (state_q == S_PLAY);
    assign key_accept = key_valid & key_ready;
    assign timer_en   = tick & (state_q == S_PLAY);

    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        miss_d        = miss_q;
        digit_d       = digit_q;
        sub_d         = sub_q;
        timer_clear_d = 1'b0;

        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d       = S_READY;
                    timer_clear_d = 1'b1;
                    score_d       = '0;
                    miss_d        = '0;
                    digit_d       = 4'(READY_SECS);
                    sub_d         = SUB_W'(TICKS_PER_SEC - 1);
                end
            end
            // The tick that empties the last second starts play but is not forwarded.
            S_READY: begin
                if (tick) begin
                    if (sub_q != '0) begin
                        sub_d = sub_q - SUB_W'(1);
                    end else if (digit_q > 4'd1) begin
                        sub_d   = SUB_W'(TICKS_PER_SEC - 1);
                        digit_d = digit_q - 4'd1;
                    end else begin
                        digit_d = 4'd0;
                        state_d = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (key_accept) begin
                    if (key_correct) begin
                        score_d = bcd_inc(score_q);
                    end else if (miss_q != {MISS_W{1'b1}}) begin
                        miss_d = miss_q + MISS_W'(1);
                    end
                end
                if (time_up) begin
                    state_d = S_OVER;
`ifdef TYPING_GAME_PAUSE_EN
                end else if (pause) begin
                    state_d = S_PAUSE;
`endif
                end
            end
`ifdef TYPING_GAME_PAUSE_EN
            S_PAUSE: begin
                if (pause) begin
                    state_d = S_PLAY;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        game_over_d = (state_d == S_OVER);
    end

    assign state       = state_q;
    assign score       = score_q;
    assign miss        = miss_q;
    assign ready_digit = digit_q;
    assign timer_clear = timer_clear_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_typing_game_ctrl.sv
// Scoreboard bench for typing_game_ctrl (READY_SECS=3, TICKS_PER_SEC=4).
module tb_typing_game_ctrl;

`ifdef TYPING_GAME_PAUSE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset, tick, start, pause, key_valid, key_correct, time_up;
    logic            key_ready, timer_clear, timer_en, game_over;
    logic [3:0]      ready_digit;
    logic [0:3][3:0] score;
    logic [7:0]      miss;
    logic [2:0]      state;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] sc;
        logic [7:0]  ms;
        logic [3:0]  dg;
        logic        go;
        logic        tc;
    } snap_t;

    snap_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    m_score = 0;
    int    m_miss = 0;

    typing_game_ctrl #(.READY_SECS(3), .TICKS_PER_SEC(4)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
        .key_valid(key_valid), .key_correct(key_correct), .key_ready(key_ready),
        .time_up(time_up), .timer_clear(timer_clear), .timer_en(timer_en),
        .ready_digit(ready_digit), .score(score), .miss(miss), .state(state),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic snap_t mk(input int st, input int dg, input bit go, input bit tc);
        snap_t s;
        s.st = 3'(st); s.sc = to_bcd(m_score); s.ms = 8'(m_miss);
        s.dg = 4'(dg); s.go = go; s.tc = tc;
        return s;
    endfunction

    function automatic snap_t obs();
        snap_t s;
        s.st = state; s.sc = score; s.ms = miss; s.dg = ready_digit;
        s.go = game_over; s.tc = timer_clear;
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("st=%0d sc=%h ms=%0d dg=%0d go=%b tc=%b", s.st, s.sc, s.ms, s.dg, s.go, s.tc);
    endfunction

    task automatic clr_in();
        tick = 0; start = 0; pause = 0; key_valid = 0; key_correct = 0; time_up = 0;
    endtask

    task automatic test_reset();
        snap_t e, o;
        reset = 1; clr_in();
        cyc();
        m_score = 0; m_miss = 0;
        sb.push_back(mk(0, 0, 0, 0));
        cyc();
        reset = 0; tick = 1;
        #1;
        o = obs(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL reset got %s want %s", fmt(o), fmt(e)); end
        n_vec++;
        if ({key_ready, timer_en} !== 2'b00) begin
            n_err++; $display("FAIL reset_comb got key_ready=%b timer_en=%b want 0 0", key_ready, timer_en);
        end
        cyc();
        tick = 0;
    endtask

    task automatic test_countdown(input bit do_start);
        snap_t e, o;
        int dg, st;
        if (do_start) begin
            start = 1; m_score = 0; m_miss = 0;
            sb.push_back(mk(1, 3, 0, 1));
            cyc(); start = 0;
            o = obs(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL start got %s want %s", fmt(o), fmt(e)); end
            sb.push_back(mk(1, 3, 0, 0));
            cyc();
            o = obs(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL clear_pulse got %s want %s", fmt(o), fmt(e)); end
        end
        for (int k = 1; k <= 12; k++) begin
            tick = 1;
            #1;
            n_vec++;
            if (timer_en !== 1'b0) begin n_err++; $display("FAIL ready_tick%0d timer_en got %b want 0", k, timer_en); end
            dg = (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0;
            st = (k == 12) ? 2 : 1;
            sb.push_back(mk(st, dg, 0, 0));
            cyc(); tick = 0;
            o = obs(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL ready_tick%0d got %s want %s", k, fmt(o), fmt(e)); end
            cyc();
        end
        tick = 1;
        #1;
        n_vec++;
        if ({timer_en, key_ready} !== 2'b11) begin
            n_err++; $display("FAIL tick13 got timer_en=%b key_ready=%b want 1 1", timer_en, key_ready);
        end
        cyc(); tick = 0;
    endtask

    task automatic test_keys();
        snap_t e, o;
        bit pat[7] = '{1, 0, 1, 1, 0, 1, 1};
        for (int i = 0; i < 7; i++) begin
            key_valid = 1; key_correct = pat[i];
            #1;
            n_vec++;
            if (key_ready !== 1'b1) begin n_err++; $display("FAIL key%0d_ready got %b want 1", i, key_ready); end
            if (pat[i]) m_score++; else m_miss++;
            sb.push_back(mk(2, 0, 0, 0));
            cyc();
            key_valid = 0; key_correct = 1'($urandom);
            o = obs(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL key%0d got %s want %s", i, fmt(o), fmt(e)); end
            for (int g = 0; g <= i % 2; g++) begin
                sb.push_back(mk(2, 0, 0, 0));
                cyc();
                o = obs(); e = sb.pop_front(); n_vec++;
                if (o !== e) begin n_err++; $display("FAIL key%0d_gap got %s want %s", i, fmt(o), fmt(e)); end
            end
        end
        n_vec++;
        if ({score, miss} !== {16'h0005, 8'd2}) begin
            n_err++; $display("FAIL key_totals got %h/%0d want 0005/2", score, miss);
        end
    endtask

    task automatic test_pause();
        snap_t e, o;
        pause = 1;
        sb.push_back(mk(PE ? 3 : 2, 0, 0, 0));
        cyc(); pause = 0;
        o = obs(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL pause_in got %s want %s", fmt(o), fmt(e)); end
        for (int j = 0; j < 3; j++) begin
            tick = 1; key_valid = 1; key_correct = 1'(j % 2);
            time_up = PE && (j == 1);
            start = PE && (j == 2);
            #1;
            n_vec++;
            if ({timer_en, key_ready} !== {!PE, !PE}) begin
                n_err++; $display("FAIL paused%0d got timer_en=%b key_ready=%b want %b %b", j, timer_en, key_ready, !PE, !PE);
            end
            if (!PE) begin
                if (j % 2 == 1) m_score++; else m_miss++;
            end
            sb.push_back(mk(PE ? 3 : 2, 0, 0, 0));
            cyc(); clr_in();
            o = obs(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL paused%0d got %s want %s", j, fmt(o), fmt(e)); end
        end
        pause = 1;
        sb.push_back(mk(2, 0, 0, 0));
        cyc(); pause = 0;
        o = obs(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL pause_out got %s want %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_simultaneous();
        snap_t e, o;
        time_up = 1; pause = 1; key_valid = 1; key_correct = 1;
        m_score++;
        sb.push_back(mk(4, 0, 1, 0));
        cyc(); clr_in();
        o = obs(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL simul got %s want %s", fmt(o), fmt(e)); end
        for (int j = 0; j < 2; j++) begin
            key_valid = 1; key_correct = 1; pause = 1'(j);
            sb.push_back(mk(4, 0, 1, 0));
            cyc(); clr_in();
            o = obs(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL over_hold%0d got %s want %s", j, fmt(o), fmt(e)); end
        end
        start = 1; m_score = 0; m_miss = 0;
        sb.push_back(mk(1, 3, 0, 1));
        cyc(); start = 0;
        o = obs(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL restart got %s want %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_saturation();
        snap_t e, o;
        key_valid = 1; key_correct = 1;
        for (int i = 0; i < 1000; i++) cyc();
        n_vec++;
        if (score !== 16'h1000) begin n_err++; $display("FAIL bcd_carry got %h want 1000", score); end
        for (int i = 0; i < 8999; i++) cyc();
        m_score = 9999;
        key_correct = 0;
        for (int i = 0; i < 255; i++) cyc();
        m_miss = 255;
        n_vec++;
        if ({score, miss} !== {16'h9999, 8'd255}) begin
            n_err++; $display("FAIL sat_load got %h/%0d want 9999/255", score, miss);
        end
        for (int j = 0; j < 2; j++) begin
            key_correct = 1'(j == 0);
            if (j == 0 && m_score < 9999) m_score++;
            if (j == 1 && m_miss < 255) m_miss++;
            sb.push_back(mk(2, 0, 0, 0));
            cyc();
            o = obs(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL sat%0d got %s want %s", j, fmt(o), fmt(e)); end
        end
        clr_in();
    endtask

    task automatic test_reset_mid_ready();
        snap_t e, o;
        time_up = 1;
        sb.push_back(mk(4, 0, 1, 0));
        cyc(); time_up = 0;
        o = obs(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL end_round got %s want %s", fmt(o), fmt(e)); end
        start = 1; cyc(); start = 0;
        m_score = 0; m_miss = 0;
        for (int k = 0; k < 4; k++) begin tick = 1; cyc(); tick = 0; cyc(); end
        sb.push_back(mk(1, 2, 0, 0));
        o = obs(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL mid_ready got %s want %s", fmt(o), fmt(e)); end
        reset = 1; tick = 1;
        sb.push_back(mk(0, 0, 0, 0));
        cyc(); reset = 0;
        o = obs(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL reset_ready got %s want %s", fmt(o), fmt(e)); end
        n_vec++;
        if ({key_ready, timer_en} !== 2'b00) begin
            n_err++; $display("FAIL reset_ready_comb got key_ready=%b timer_en=%b want 0 0", key_ready, timer_en);
        end
        clr_in();
    endtask

    initial begin
        reset = 1; clr_in();
        test_reset();
        test_countdown(1'b1);
        test_keys();
        test_pause();
        test_simultaneous();
        test_countdown(1'b0);
        test_saturation();
        test_reset_mid_ready();
        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
